// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: memory-map defaults and the sequencer state
// encoding, so the hazard unit and debug logic can decode STALL and HALT.
package fetch_ctrl_pkg;

  localparam logic [31:0] TEXT_START_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES_DEF   = 32'h0000_4000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input fetch_state_e s);
    return s == ST_HALT;
  endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Classifies the address about to be loaded into the PC: AdEL (misaligned or
// below text) versus past the end of instruction memory (halt boundary).
module fetch_addr_check
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TEXT_START = TEXT_START_DEF,
  parameter logic [31:0] IM_BYTES   = IM_BYTES_DEF
) (
  input  logic [31:0] addr,
  output logic        adel,
  output logic        beyond
);

  // 33-bit limit so a text segment ending at 4 GiB cannot wrap the compare
  localparam logic [32:0] LIMIT = {1'b0, TEXT_START} + {1'b0, IM_BYTES};

  logic misaligned;
  logic below;

  always_comb begin
    misaligned = addr[1:0] != 2'b00;
    below      = addr < TEXT_START;
    adel       = misaligned || below;
    beyond     = {1'b0, addr} >= LIMIT;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC and applies reset, exception, ERET, halt and
// stall priority to the next-PC calculator's result; also counts PC advances.
//
// state    | meaning
// ST_RUN   | fetching, PC advances from npc_in each cycle
// ST_STALL | hazard freeze, PC/bd/fetch_exc/count held
// ST_HALT  | fetched past end of text; only exc/eret/reset leave
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] TEXT_START = TEXT_START_DEF,
  parameter logic [31:0] IM_BYTES   = IM_BYTES_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc_in,
  input  logic        branch_in_id,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        bd_out,
  output logic        fetch_exc,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  fetch_state_e state, state_n;

  logic        load;
  logic        cnt_inc;
  logic [31:0] load_addr;
  logic        load_bd;
  logic        adel;
  logic        beyond;

  fetch_addr_check #(
    .TEXT_START (TEXT_START),
    .IM_BYTES   (IM_BYTES)
  ) u_addr_check (
    .addr   (load_addr),
    .adel   (adel),
    .beyond (beyond)
  );

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    cnt_inc   = 1'b0;
    load_addr = npc_in;
    load_bd   = branch_in_id;

    if (exc_req) begin
      load      = 1'b1;
      load_addr = EXC_VECTOR;
      load_bd   = 1'b0;
    end else if (eret_req) begin
      load      = 1'b1;
      load_addr = epc_in;
      load_bd   = 1'b0;
    end else if (state == ST_HALT) begin
      state_n = ST_HALT;
    end else if (stall) begin
      state_n = ST_STALL;
    end else begin
      load    = 1'b1;
      cnt_inc = 1'b1;
    end

    // AdEL takes precedence: a faulting address reports, it does not halt
    if (load) begin
      state_n = (beyond && !adel) ? ST_HALT : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      pc_out    <= TEXT_START;
      pc_valid  <= 1'b1;
      bd_out    <= 1'b0;
      fetch_exc <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      state <= state_n;
      if (load) begin
        pc_out    <= load_addr;
        pc_valid  <= !adel && !beyond;
        bd_out    <= load_bd;
        fetch_exc <= adel;
      end
      if (cnt_inc) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  assign halted = is_halt(state);

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer that owns the architectural PC register and decides, every cycle, which address the instruction memory fetches next. It sits in the IF stage and wraps the next-PC calculator's combinational result with stall, exception-redirect, ERET-return, halt and delay-slot tracking. It also maintains a fetch counter for debug.

## Interface
- `TEXT_START`, default 32'h0000_3000: PC value loaded at reset and the lowest legal fetch address.
- `IM_BYTES`, default 32'h0000_4000: instruction memory size in bytes; the halt boundary is `TEXT_START + IM_BYTES`.
- `EXC_VECTOR`, default 32'h0000_4180: exception handler entry address.

Ports:
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-low. It wins over every other input.
- `stall` input, 1: hazard-unit freeze of the IF stage.
- `npc_in` input, 32: next PC from the next-PC calculator.
- `branch_in_id` input, 1: the instruction currently in ID is a branch or jump.
- `exc_req` input, 1: an exception or interrupt was taken this cycle; redirect to `EXC_VECTOR`.
- `eret_req` input, 1: ERET committed this cycle; redirect to `epc_in`.
- `epc_in` input, 32: return address from CP0.
- `pc_out` output, 32: registered fetch address.
- `pc_valid` output, 1: `pc_out` is a legal fetch; 0 means IF injects a bubble.
- `bd_out` output, 1: `pc_out` is a branch delay slot.
- `fetch_exc` output, 1: `pc_out` is misaligned or outside text (AdEL on fetch).
- `halted` output, 1: the controller is in HALT.
- `fetch_cnt` output, 32: count of accepted PC advances.

## Operation
State machine with three states, encoded in 2 bits: RUN, STALL, HALT.

Next-PC selection, in priority order:
1. `reset` low: all outputs return to their reset values.
2. `exc_req`: load `EXC_VECTOR`; clear `bd_out`; go to RUN. This overrides `stall`, `eret_req` and HALT.
3. `eret_req`: load `epc_in`; clear `bd_out`; go to RUN. This overrides `stall` and HALT.
4. In HALT: hold all registers.
5. `stall`: hold `pc_out`, `bd_out`, `fetch_exc` and `fetch_cnt`; go to STALL.
6. Otherwise: load `npc_in`; set `bd_out` to `branch_in_id`; increment `fetch_cnt`; go to RUN.

Legality of each loaded address, computed on the value being loaded:
- If bits [1:0] are nonzero, or the address is below `TEXT_START`, then `fetch_exc`=1 and `pc_valid`=0.
- If the address is greater than or equal to `TEXT_START + IM_BYTES`, then go to HALT with `halted`=1 and `pc_valid`=0. `fetch_exc` stays 0 in this case.
- Otherwise `pc_valid`=1 and `fetch_exc`=0.

Other rules:
- STALL to RUN happens on the first cycle with `stall`=0; that cycle loads `npc_in` as in step 6.
- `fetch_cnt` wraps modulo 2^32. Redirects caused by `exc_req` or `eret_req` do not increment it.
- All address arithmetic is unsigned 32-bit. The halt comparison must not overflow: compare against a 33-bit sum or a precomputed constant.

## Timing
- Reset values:
  - `pc_out`=`TEXT_START`, `pc_valid`=1, `bd_out`=0, `fetch_exc`=0, `halted`=0, `fetch_cnt`=0.
  - State is RUN.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: `npc_in`, `exc_req` and `eret_req` sampled at edge N appear on `pc_out` after edge N.
- Simultaneous `exc_req` and `eret_req`: the exception wins.
- Simultaneous `exc_req` and `stall`: redirect happens; the stall is ignored for that cycle.
- `reset` asserted mid-stall or mid-halt: reset values appear after the next edge.

## Structure
- Constants go in the shared memory-config header and are passed as parameters: `TEXT_START`, `IM_BYTES`, `EXC_VECTOR`.
- The state encoding goes in a local shared package so the hazard unit and debug logic can decode `halted` and STALL.
- One sub-module, `fetch_addr_check`: combinational alignment, lower-bound and upper-bound classification of the address being loaded. It is instantiated once.

## Test plan
- Reset, then 3 unstalled cycles with `npc_in`=`pc_out`+4 → `pc_out` goes 0x3000, 0x3004, 0x3008, 0x300C; `fetch_cnt`=3.
- `stall` high for 2 cycles at `pc_out`=0x3008 → `pc_out` stays 0x3008 and `fetch_cnt` is frozen; the first cycle after `stall` falls loads `npc_in`.
- `branch_in_id`=1 with `npc_in`=0x3010 → `pc_out`=0x3010 and `bd_out`=1; on the next advance `bd_out`=0.
- `exc_req`, `eret_req` (`epc_in`=0x3020) and `stall` all high together → `pc_out`=0x4180, `bd_out`=0. The following cycle with only `eret_req` high → `pc_out`=0x3020.
- `npc_in`=0x3002 → `fetch_exc`=1, `pc_valid`=0. Then `npc_in`=0x7000 → `halted`=1 and `pc_out` holds at 0x7000 despite further `npc_in` changes; a later `exc_req` → `pc_out`=0x4180 with `halted`=0.
- `reset` low while in HALT or STALL → all outputs return to their reset values after one edge.
